// File: rtl/decoder_seq_if.sv
// Command/result bundle for decoder_seq. The controller drives the command side
// through the master modport, and the decoder serves it through the slave modport.
interface decoder_seq_if #(
  parameter int IN_W    = 3,
  parameter int DWELL_W = 4
);
  localparam int OUT_W = 2 ** IN_W;

  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in;
  logic [1:0]         mode;
  logic [DWELL_W-1:0] dwell;
  logic               stop;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic               busy;

  modport master (
    output in_valid, in, mode, dwell, stop,
    input  in_ready, out, out_valid, busy
  );

  modport slave (
    input  in_valid, in, mode, dwell, stop,
    output in_ready, out, out_valid, busy
  );
endinterface

// File: rtl/decoder_seq.sv
// Registered IN_W-to-2**IN_W decoder with one-hot, thermometer and active-low modes,
// plus a scan mode that walks one hot bit across every output with a programmable dwell.
module decoder_seq #(
  parameter int IN_W    = 3,
  parameter int DWELL_W = 4
) (
  input logic          clk,
  input logic          rst,
  decoder_seq_if.slave bus
);
  localparam int OUT_W = 2 ** IN_W;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state_q, state_d;
  logic [IN_W-1:0]    idx_q, idx_d;
  logic [IN_W-1:0]    pos_q, pos_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] lim_q, lim_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   one_hot;
  logic [OUT_W-1:0]   therm;
  logic               accept;

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == SCAN);
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    one_hot = '0;
    one_hot[bus.in] = 1'b1;
    therm = '0;
    for (int i = 0; i < OUT_W; i++) begin
      therm[i] = (i <= int'(bus.in));
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    cnt_d       = cnt_q;
    lim_d       = lim_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          out_valid_d = 1'b1;
          case (bus.mode)
            2'b00: out_d = one_hot;
            2'b01: out_d = therm;
            2'b10: out_d = ~one_hot;
            default: begin
              state_d = SCAN;
              idx_d   = bus.in;
              pos_d   = '0;
              cnt_d   = '0;
              lim_d   = bus.dwell;
              out_d   = one_hot;
            end
          endcase
        end
      end
      SCAN: begin
        // stop outranks the final dwell expiry so an abort always blanks the outputs
        if (bus.stop) begin
          state_d     = IDLE;
          pos_d       = '0;
          cnt_d       = '0;
          out_d       = '0;
          out_valid_d = 1'b1;
        end else if (cnt_q != lim_q) begin
          cnt_d = cnt_q + 1'b1;
        end else if (pos_q == IN_W'(OUT_W - 1)) begin
          state_d = IDLE;
          pos_d   = '0;
          cnt_d   = '0;
        end else begin
          idx_d       = idx_q + 1'b1;
          pos_d       = pos_q + 1'b1;
          cnt_d       = '0;
          out_d       = '0;
          out_d[idx_d] = 1'b1;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pos_q       <= '0;
      cnt_q       <= '0;
      lim_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      cnt_q       <= cnt_d;
      lim_q       <= lim_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq: directed commands push expected pulses, a negedge
// monitor pops and checks them; a second IN_W=4 instance covers the parameter scaling.
module tb_decoder_seq;
  typedef struct {
    logic [7:0] val;
    int         gap;
  } exp_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   cyc;
  int   last_pulse;
  exp_t exp_q[$];

  decoder_seq_if #(.IN_W(3), .DWELL_W(4)) bus ();
  decoder_seq_if #(.IN_W(4), .DWELL_W(4)) bus4 ();

  decoder_seq #(.IN_W(3), .DWELL_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  decoder_seq #(.IN_W(4), .DWELL_W(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic pushExp(input logic [7:0] v, input int gap);
    exp_t e;
    e.val = v;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Drive one command for one edge; caller is at posedge+1 and returns at posedge+1.
  task automatic applyStimulus(input logic [1:0] m, input logic [2:0] i, input logic [3:0] d,
                               input logic [7:0] ev, input int gap);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.in       = i;
    bus.dwell    = d;
    pushExp(ev, gap);
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(output int n, output logic ready_at_idle);
    n = 0;
    ready_at_idle = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ready_at_idle = bus.in_ready;
        break;
      end
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every out_valid pulse must match the head of the expectation queue.
  initial begin
    exp_t e;
    cyc = 0;
    last_pulse = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_pulse: got out=%h, expected no pulse at %0t", bus.out, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("sb_out", 32'(bus.out), 32'(e.val));
          if (e.gap > 0) checkOutput("sb_gap", 32'(cyc - last_pulse), 32'(e.gap));
        end
        last_pulse = cyc;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] onehot_tbl [8];
    int         n;
    int         ready_hi;
    int         pulses;
    logic       rdy;

    onehot_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in = '0; bus.mode = '0; bus.dwell = '0; bus.stop = 1'b0;
    bus4.in_valid = 1'b0; bus4.in = '0; bus4.mode = '0; bus4.dwell = '0; bus4.stop = 1'b0;

    #3;
    checkOutput("reset_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("reset_out", 32'(bus.out), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release_ready", 32'(bus.in_ready), 32'd1);

    // One-hot sweep, then active-low and thermometer, all back-to-back
    for (int i = 0; i < 8; i++) applyStimulus(2'b00, 3'(i), 4'd0, onehot_tbl[i], (i == 0) ? 0 : 1);
    applyStimulus(2'b10, 3'd5, 4'd0, 8'hDF, 1);
    applyStimulus(2'b01, 3'd0, 4'd0, 8'h01, 1);
    applyStimulus(2'b01, 3'd3, 4'd0, 8'h0F, 1);
    applyStimulus(2'b01, 3'd7, 4'd0, 8'hFF, 1);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("hold_out", 32'(bus.out), 32'hFF);
    checkOutput("hold_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("static_queue", 32'(exp_q.size()), 32'd0);

    // stop is ignored in IDLE, including on the acceptance edge
    bus.stop = 1'b1;
    applyStimulus(2'b00, 3'd3, 4'd0, 8'h08, 0);
    bus.in_valid = 1'b0;
    bus.stop = 1'b0;
    checkOutput("stop_idle_busy", 32'(bus.busy), 32'd0);

    // Scan with wrap from 6, dwell 2, plus an in_valid pulse that must be ignored
    applyStimulus(2'b11, 3'd6, 4'd2, 8'h40, 0);
    bus.in_valid = 1'b0;
    pushExp(8'h80, 3); pushExp(8'h01, 3); pushExp(8'h02, 3); pushExp(8'h04, 3);
    pushExp(8'h08, 3); pushExp(8'h10, 3); pushExp(8'h20, 3);
    n = 0;
    ready_hi = 0;
    rdy = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 5) begin
        bus.in_valid = 1'b1; bus.mode = 2'b00; bus.in = 3'd1;
      end
      if (k == 6) bus.in_valid = 1'b0;
      if (!bus.busy) begin
        rdy = bus.in_ready;
        break;
      end
      n++;
      if (bus.in_ready) ready_hi++;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("scan_busy_cycles", 32'(n), 32'd24);
    checkOutput("scan_ready_low", 32'(ready_hi), 32'd0);
    checkOutput("scan_ready_after", 32'(rdy), 32'd1);
    checkOutput("scan_final_out", 32'(bus.out), 32'h20);
    checkOutput("scan_queue", 32'(exp_q.size()), 32'd0);

    // dwell 0: one position per cycle
    applyStimulus(2'b11, 3'd0, 4'd0, 8'h01, 0);
    bus.in_valid = 1'b0;
    for (int i = 1; i < 8; i++) pushExp(onehot_tbl[i], 1);
    waitIdle(n, rdy);
    checkOutput("dwell0_busy", 32'(n), 32'd8);
    checkOutput("dwell0_final", 32'(bus.out), 32'h80);
    checkOutput("dwell0_queue", 32'(exp_q.size()), 32'd0);

    // stop on the final dwell edge of a scan from 2, dwell 1
    applyStimulus(2'b11, 3'd2, 4'd1, 8'h04, 0);
    bus.in_valid = 1'b0;
    pushExp(8'h08, 2); pushExp(8'h10, 2); pushExp(8'h20, 2); pushExp(8'h40, 2);
    pushExp(8'h80, 2); pushExp(8'h01, 2); pushExp(8'h02, 2);
    pushExp(8'h00, 2);
    repeat (15) @(posedge clk);
    #1 bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.stop = 1'b0;
    checkOutput("stop_out", 32'(bus.out), 32'h00);
    checkOutput("stop_busy", 32'(bus.busy), 32'd0);
    checkOutput("stop_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("stop_queue", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a scan from 1, dwell 3
    applyStimulus(2'b11, 3'd1, 4'd3, 8'h02, 0);
    bus.in_valid = 1'b0;
    pushExp(8'h04, 4);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_out", 32'(bus.out), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("midrst_queue", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_ready_after", 32'(bus.in_ready), 32'd1);
    checkOutput("midrst_out_after", 32'(bus.out), 32'd0);

    // IN_W=4 instance: one-hot top bit, then a 16-position dwell-0 scan
    bus4.in_valid = 1'b1; bus4.mode = 2'b00; bus4.in = 4'd15;
    @(posedge clk);
    #1 bus4.in_valid = 1'b0;
    checkOutput("w4_onehot", 32'(bus4.out), 32'h8000);
    checkOutput("w4_valid", 32'(bus4.out_valid), 32'd1);
    bus4.in_valid = 1'b1; bus4.mode = 2'b11; bus4.in = 4'd0; bus4.dwell = 4'd0;
    @(posedge clk);
    #1 bus4.in_valid = 1'b0;
    checkOutput("w4_scan_start", 32'(bus4.out), 32'h0001);
    n = 0;
    pulses = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus4.busy) break;
      n++;
      if (bus4.out_valid) pulses++;
    end
    checkOutput("w4_scan_cycles", 32'(n), 32'd16);
    checkOutput("w4_scan_pulses", 32'(pulses), 32'd16);
    checkOutput("w4_scan_final", 32'(bus4.out), 32'h8000);
    checkOutput("w4_ready_after", 32'(bus4.in_ready), 32'd1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
